// File: rtl/stopwatch_control_if.sv
// Bundle between the stopwatch control front-end and its environment:
// raw buttons/switch and digit-chain status in, digit-chain controls out.
interface stopwatch_control_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       mode_down;
  logic       expired;
  logic       tick_enable;
  logic       counter_clear;
  logic       up_down;
  logic       running;
  logic [1:0] state;

  modport master (
    output btn_start_stop, btn_clear, mode_down, expired,
    input  tick_enable, counter_clear, up_down, running, state
  );

  modport slave (
    input  btn_start_stop, btn_clear, mode_down, expired,
    output tick_enable, counter_clear, up_down, running, state
  );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch control: button synchronise/debounce, IDLE/RUNNING/PAUSED/DONE FSM,
// tick prescaler and the shared enable/up_down/clear drive for the digit chain.
module stopwatch_control #(
  parameter int unsigned CLK_FREQ_HZ     = 100000000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_control_if.slave  bus
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned NB  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    DONE    = 2'b11
  } state_t;

  // index 0 = start/stop, index 1 = clear
  logic [NB-1:0] raw;
  logic [NB-1:0] sync1, sync2, level, level_d, press;
  logic [CW-1:0] db_cnt [NB];
  logic          mode1, mode_sync;

  state_t        state_q, state_next;
  logic [PW-1:0] presc_q, presc_next;
  logic          up_down_q, up_down_next;
  logic          clear_q, clear_next;
  logic          tick_q, tick_next;
  logic          running_q;
  logic          halt;

  assign raw = {bus.btn_clear, bus.btn_start_stop};

  // Synchronisers, debounce counters and rising-edge press pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      level_d   <= '0;
      press     <= '0;
      mode1     <= 1'b0;
      mode_sync <= 1'b0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      mode1     <= bus.mode_down;
      mode_sync <= mode1;
      level_d   <= level;
      press     <= level & ~level_d;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Next state, clear/tick decisions and prescaler update
  always_comb begin
    state_next   = state_q;
    clear_next   = 1'b0;
    up_down_next = up_down_q;
    presc_next   = presc_q;
    halt         = ~up_down_q & bus.expired;

    unique case (state_q)
      IDLE: begin
        if (press[1])      clear_next = 1'b1;
        else if (press[0]) state_next = RUNNING;
      end
      RUNNING: begin
        if (press[1]) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end else if (press[0]) begin
          state_next = PAUSED;
        end else if (halt) begin
          state_next = DONE;
        end
      end
      PAUSED: begin
        if (press[1]) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end else if (press[0]) begin
          state_next = RUNNING;
        end
      end
      DONE: begin
        if (press[1]) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end
      end
    endcase

    // Mode is only sampled while idle; a change restarts the digits
    if (state_next == IDLE) begin
      up_down_next = ~mode_sync;
      if (up_down_next != up_down_q) clear_next = 1'b1;
    end

    tick_next = (state_q == RUNNING) && (presc_q == PW'(DIV - 1)) && !halt;

    if (clear_next || (state_q == IDLE && state_next == RUNNING)) begin
      presc_next = '0;
    end else if (state_q == RUNNING && !halt) begin
      presc_next = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      up_down_q <= 1'b1;
      clear_q   <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      presc_q   <= presc_next;
      up_down_q <= up_down_next;
      clear_q   <= clear_next;
      tick_q    <= tick_next;
      running_q <= (state_next == RUNNING);
    end
  end

  assign bus.state         = state_q;
  assign bus.up_down       = up_down_q;
  assign bus.counter_clear = clear_q;
  assign bus.tick_enable   = tick_q;
  assign bus.running       = running_q;

endmodule
